// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: state encoding and widths.
package uart_pkg;

  localparam int unsigned ARB_ID_W = 3;
  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned CLK_DIV  = 4;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_TAG  = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Producer-side and UART-side handshake bundle for uart_tx_arbiter.
interface uart_tx_arbiter_if #(
  parameter int unsigned NREQ = 2
);
  import uart_pkg::*;

  logic [NREQ-1:0]        req_valid;
  logic [BYTE_W*NREQ-1:0] req_data;
  logic [NREQ-1:0]        req_last;
  logic [NREQ-1:0]        req_ready;
  logic                   uart_valid;
  logic [BYTE_W-1:0]      uart_data;
  logic                   uart_tx_done;

  modport slave (
    input  req_valid, req_data, req_last, uart_tx_done,
    output req_ready, uart_valid, uart_data
  );

  modport master (
    output req_valid, req_data, req_last, uart_tx_done,
    input  req_ready, uart_valid, uart_data
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping NREQ-1 -> 0.
module rr_pick
  import uart_pkg::*;
#(
  parameter int unsigned NREQ = 2
) (
  input  logic [NREQ-1:0]     req,
  input  logic [ARB_ID_W-1:0] ptr,
  output logic                any,
  output logic [ARB_ID_W-1:0] idx
);

  localparam logic [ARB_ID_W:0] NREQ_W = (ARB_ID_W+1)'(NREQ);

  logic [2*NREQ-1:0]   dbl;
  logic [NREQ-1:0]     rot;
  logic [ARB_ID_W-1:0] off;
  logic [ARB_ID_W:0]   sum;

  always_comb begin
    dbl = {req, req};
    rot = NREQ'(dbl >> ptr);
    any = |req;
    off = '0;
    // Descending scan so the lowest rotated position is the one left standing.
    for (int unsigned i = NREQ; i > 0; i--) begin
      if (rot[i-1]) off = ARB_ID_W'(i - 1);
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= NREQ_W) sum = sum - NREQ_W;
    idx = sum[ARB_ID_W-1:0];
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked sharing of one UART transmitter among NREQ producers.
// Optional tag byte per grant when UART_ARB_TAG_EN is defined.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned       NREQ      = 2,
  parameter int unsigned       MAX_BURST = 64,
  parameter logic [BYTE_W-1:0] TAG_BASE  = 8'hF0
) (
  input  logic                clk,
  input  logic                rst_n,
  uart_tx_arbiter_if.slave    bus,
  output logic [ARB_ID_W-1:0] grant_id,
  output logic                busy
);

  localparam logic [ARB_ID_W:0] NREQ_W   = (ARB_ID_W+1)'(NREQ);
  localparam logic [7:0]        LAST_CNT = 8'(MAX_BURST - 1);

  arb_state_e          state_q, state_d;
  logic [ARB_ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ARB_ID_W-1:0] grant_q, grant_d;
  logic [7:0]          burst_q, burst_d;

  logic                pick_any;
  logic [ARB_ID_W-1:0] pick_idx;
  logic                sel_valid, sel_last;
  logic [BYTE_W-1:0]   sel_data;
  logic [ARB_ID_W:0]   next_ptr;
  logic [NREQ-1:0]     ready;
  logic                uvalid;
  logic [BYTE_W-1:0]   udata;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req (bus.req_valid),
    .ptr (rr_ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_q == ARB_ID_W'(i)) begin
        sel_valid = bus.req_valid[i];
        sel_last  = bus.req_last[i];
        sel_data  = bus.req_data[i*BYTE_W +: BYTE_W];
      end
    end
    next_ptr = {1'b0, grant_q} + (ARB_ID_W+1)'(1);
    if (next_ptr >= NREQ_W) next_ptr = '0;
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    burst_d  = burst_q;
    uvalid   = 1'b0;
    udata    = '0;
    ready    = '0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          burst_d = '0;
`ifdef UART_ARB_TAG_EN
          state_d = ARB_TAG;
`else
          state_d = ARB_DATA;
`endif
        end
      end
      // Unreachable unless the tag feature is built in; keeps the encoding fixed.
      ARB_TAG: begin
        uvalid = 1'b1;
        udata  = TAG_BASE | BYTE_W'(grant_q);
        if (bus.uart_tx_done) state_d = ARB_DATA;
      end
      ARB_DATA: begin
        uvalid = sel_valid;
        udata  = sel_valid ? sel_data : '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
          ready[i] = bus.uart_tx_done && bus.req_valid[i] && (grant_q == ARB_ID_W'(i));
        end
        if (sel_valid && bus.uart_tx_done) begin
          burst_d = burst_q + 8'd1;
          if (sel_last || burst_q == LAST_CNT) begin
            rr_ptr_d = next_ptr[ARB_ID_W-1:0];
            state_d  = ARB_IDLE;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      burst_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      burst_q  <= burst_d;
    end
  end

  assign bus.req_ready  = ready;
  assign bus.uart_valid = uvalid;
  assign bus.uart_data  = udata;
  assign grant_id       = grant_q;
  assign busy           = (state_q != ARB_IDLE);

endmodule
